// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared state encoding and width helper for the keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle     = 3'd0;
    localparam logic [c_state_w-1:0] c_st_scan     = 3'd1;
    localparam logic [c_state_w-1:0] c_st_debounce = 3'd2;
    localparam logic [c_state_w-1:0] c_st_held     = 3'd3;
    localparam logic [c_state_w-1:0] c_st_release  = 3'd4;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE     = c_st_idle,
        ST_SCAN     = c_st_scan,
        ST_DEBOUNCE = c_st_debounce,
        ST_HELD     = c_st_held,
        ST_RELEASE  = c_st_release
    } state_t;

    // Bits needed to index 'value' items; never less than one.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync
// Description : Parametrised-width two-flop synchroniser, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : Column-scanning keypad decoder with debounce, multi-row reject
//               and valid/ready output. KEYPAD_REPEAT_EN adds auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS            = 4,
    parameter  int COLS            = 4,
    parameter  int SCAN_HOLD       = 3,
    parameter  int DEBOUNCE_CYCLES = 4,
    parameter  int REPEAT_DELAY    = 64,
    parameter  int REPEAT_PERIOD   = 16,
    localparam int CODE_W          = clog2(ROWS * COLS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic              multi_key,
    output logic              overflow
);

    localparam int c_col_w = clog2(COLS);
    localparam int c_row_w = clog2(ROWS);
    localparam int c_cnt_w = clog2(((SCAN_HOLD > DEBOUNCE_CYCLES) ? SCAN_HOLD : DEBOUNCE_CYCLES) + 1);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(SCAN_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_deb_done  = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_rel_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(COLS - 1);

    generate
        if (ROWS < 2 || COLS < 2 || SCAN_HOLD < 3 || DEBOUNCE_CYCLES < 1 ||
            REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("keypad_matrix_scanner: illegal parameter value");
        end
    endgenerate

    logic [ROWS-1:0]    w_s_row;
    state_t             r_state,     w_state_nxt;
    logic [c_col_w-1:0] r_col_idx,   w_col_idx_nxt;
    logic [c_cnt_w-1:0] r_cnt,       w_cnt_nxt;
    logic [ROWS-1:0]    r_pattern,   w_pattern_nxt;
    logic               w_press_emit;
    logic               w_multi_evt;
    logic               w_rep_emit;
    logic               w_emit;
    logic [c_row_w-1:0] w_row_idx;
    logic [CODE_W-1:0]  w_new_code;
    logic [CODE_W-1:0]  r_code;
    logic               r_valid;
    logic               r_multi_key;
    logic               r_overflow;

    keypad_sync #(
        .WIDTH (ROWS)
    ) u_row_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_async (row),
        .o_sync  (w_s_row)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_col_idx <= '0;
            r_cnt     <= '0;
            r_pattern <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pattern <= w_pattern_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_idx_nxt = r_col_idx;
        w_cnt_nxt     = r_cnt;
        w_pattern_nxt = r_pattern;
        w_press_emit  = 1'b0;
        w_multi_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_s_row) begin
                    w_state_nxt   = ST_SCAN;
                    w_col_idx_nxt = '0;
                    w_cnt_nxt     = '0;
                end
            end
            ST_SCAN: begin
                if (r_cnt == c_hold_last) begin
                    w_cnt_nxt = '0;
                    if (|w_s_row) begin
                        w_state_nxt   = ST_DEBOUNCE;
                        w_pattern_nxt = w_s_row;
                    end else if (r_col_idx == c_col_last) begin
                        w_state_nxt   = ST_IDLE;
                        w_col_idx_nxt = '0;
                    end else begin
                        w_col_idx_nxt = r_col_idx + c_col_w'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (w_s_row == '0) begin
                    w_cnt_nxt = '0;
                    if (r_col_idx == c_col_last) begin
                        w_state_nxt   = ST_IDLE;
                        w_col_idx_nxt = '0;
                    end else begin
                        w_state_nxt   = ST_SCAN;
                        w_col_idx_nxt = r_col_idx + c_col_w'(1);
                    end
                end else if (w_s_row != r_pattern) begin
                    w_pattern_nxt = w_s_row;
                    w_cnt_nxt     = '0;
                end else if (r_cnt == c_deb_done) begin
                    w_state_nxt  = ST_HELD;
                    w_cnt_nxt    = '0;
                    w_press_emit = $onehot(r_pattern);
                    w_multi_evt  = !$onehot(r_pattern);
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            ST_HELD: begin
                if (w_s_row == '0) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                if (|w_s_row) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_rel_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_col_idx_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_col_idx_nxt = '0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int c_rep_w = clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_phase;

    // The pattern is frozen in HELD/RELEASE, so one-hot marks an accepted key.
    assign w_rep_emit = (r_state == ST_HELD) && $onehot(r_pattern) &&
                        (r_rep_phase ? (r_rep_cnt == c_period_last)
                                     : (r_rep_cnt == c_delay_last));

    // Frozen through RELEASE so a release bounce does not restart the delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (r_state != ST_HELD && r_state != ST_RELEASE) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (r_state == ST_HELD && $onehot(r_pattern)) begin
            if (w_rep_emit) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
            end
        end
    end
`else
    assign w_rep_emit = 1'b0;
`endif

    always_comb begin
        w_row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r_pattern[i]) begin
                w_row_idx = c_row_w'(i);
            end
        end
    end

    assign w_new_code = CODE_W'(int'(w_row_idx) * COLS + int'(r_col_idx));
    assign w_emit     = w_press_emit | w_rep_emit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_multi_key <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_multi_key <= w_multi_evt;
            r_overflow  <= w_emit && r_valid && !ready;
            if (w_emit) begin
                if (!r_valid || ready) begin
                    r_code  <= w_new_code;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        if (r_state == ST_IDLE) begin
            col = '1;
        end else begin
            col = COLS'(1) << r_col_idx;
        end
    end

    assign code      = r_code;
    assign valid     = r_valid;
    assign multi_key = r_multi_key;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_scanner
// Description : Directed self-checking bench for keypad_matrix_scanner (4x4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        valid;
    logic        ready = 1'b1;
    logic        multi_key;
    logic        overflow;
    logic [15:0] keys = '0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // Passive keypad: a row reads high when a pressed key sits on a driven column.
    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS+c] && col[c]) row[r] = 1'b1;
            end
        end
    end

    keypad_matrix_scanner dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .code      (code),
        .valid     (valid),
        .ready     (ready),
        .multi_key (multi_key),
        .overflow  (overflow)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        keys    = '0;
        ready   = 1'b1;
        tick(2);
        checks++; if (col !== 4'b1111) begin errors++; $display("FAIL reset_col: got %b expected 1111", col); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", code); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_multi: got %b expected 0", multi_key); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset_n = 1'b1;
        tick(10);
        checks++; if (col !== 4'b1111) begin errors++; $display("FAIL idle_col: got %b expected 1111", col); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", valid); end
    endtask

    task automatic test_single_key;
        int vcount;
        keys[6] = 1'b1;
        tick(16);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid got %b expected 0 at edge 16", valid); end
        tick(1);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL latency_17: valid got %b expected 1 at edge 17", valid); end
        checks++; if (code !== 4'd6) begin errors++; $display("FAIL single_code: got %0d expected 6", code); end
        vcount = 0;
        for (int i = 0; i < 99; i++) begin
            tick(1);
            if (valid) vcount++;
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL single_once: extra valid cycles got %0d expected 0", vcount); end
        keys = '0;
        tick(20);
        checks++; if (code !== 4'd6) begin errors++; $display("FAIL code_hold: got %0d expected 6", code); end
    endtask

    task automatic test_bounce;
        int vcount;
        logic [3:0] seen;
        vcount = 0;
        seen   = '0;
        for (int i = 0; i < 3; i++) begin
            keys[5] = 1'b1; tick(1); if (valid) begin vcount++; seen = code; end
            keys[5] = 1'b0; tick(1); if (valid) begin vcount++; seen = code; end
        end
        keys[5] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (valid) begin vcount++; seen = code; end
        end
        checks++; if (vcount !== 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", vcount); end
        checks++; if (seen !== 4'd5) begin errors++; $display("FAIL bounce_code: got %0d expected 5", seen); end
        vcount = 0;
        keys[5] = 1'b0;
        for (int i = 0; i < 2; i++) begin tick(1); if (valid) vcount++; end
        keys[5] = 1'b1;
        for (int i = 0; i < 30; i++) begin tick(1); if (valid) vcount++; end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL glitch_reemit: got %0d expected 0", vcount); end
        keys = '0;
        tick(20);
    endtask

    task automatic test_multi_key;
        int mcount;
        int vcount;
        int lat;
        mcount = 0;
        vcount = 0;
        keys[1] = 1'b1;
        keys[9] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (multi_key) mcount++;
            if (valid) vcount++;
        end
        checks++; if (mcount !== 1) begin errors++; $display("FAIL multi_pulse: got %0d expected 1", mcount); end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL multi_novalid: got %0d expected 0", vcount); end
        keys = '0;
        tick(20);
        keys[5] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (valid && lat == 0) lat = i;
        end
        checks++; if (lat !== 14) begin errors++; $display("FAIL key5_latency: got %0d expected 14", lat); end
        checks++; if (code !== 4'd5) begin errors++; $display("FAIL key5_code: got %0d expected 5", code); end
        keys = '0;
        tick(20);
    endtask

    task automatic test_overflow;
        int ocount;
        int lat;
        ready   = 1'b0;
        keys[3] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick(1);
            if (valid) lat = i;
        end
        checks++; if (lat !== 20) begin errors++; $display("FAIL key3_latency: got %0d expected 20", lat); end
        keys = '0;
        tick(20);
        ocount  = 0;
        keys[9] = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(1); if (overflow) ocount++; end
        keys = '0;
        for (int i = 0; i < 20; i++) begin tick(1); if (overflow) ocount++; end
        checks++; if (ocount !== 1) begin errors++; $display("FAIL overflow_pulse: got %0d expected 1", ocount); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL overflow_valid: got %b expected 1", valid); end
        checks++; if (code !== 4'd3) begin errors++; $display("FAIL overflow_code: got %0d expected 3", code); end
        ready = 1'b1;
        tick(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", valid); end
        checks++; if (code !== 4'd3) begin errors++; $display("FAIL drain_code: got %0d expected 3", code); end
    endtask

    task automatic test_reset_mid;
        int lat;
        ready   = 1'b0;
        keys[6] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick(1);
            if (valid) lat = i;
        end
        checks++; if (lat !== 17) begin errors++; $display("FAIL prereset_latency: got %0d expected 17", lat); end
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (col !== 4'b1111) begin errors++; $display("FAIL async_col: got %b expected 1111", col); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", valid); end
        checks++; if (code !== 4'd0) begin errors++; $display("FAIL async_code: got %0d expected 0", code); end
        keys  = '0;
        ready = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(10);
        checks++; if (col !== 4'b1111) begin errors++; $display("FAIL post_col: got %b expected 1111", col); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_valid: got %b expected 0", valid); end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat;
        int times[$];
        int expected[5];
        expected = '{11, 75, 91, 107, 123};
        ready   = 1'b1;
        keys[0] = 1'b1;
        for (int i = 1; i <= 220; i++) begin
            tick(1);
            if (valid) times.push_back(i);
            if (i == 120) keys[0] = 1'b0;
        end
        checks++; if (times.size() !== 5) begin errors++; $display("FAIL repeat_count: got %0d expected 5", times.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < times.size()) begin
                checks++;
                if (times[k] !== expected[k]) begin
                    errors++;
                    $display("FAIL repeat_time%0d: got %0d expected %0d", k, times[k], expected[k]);
                end
            end
        end
        tick(20);
    endtask
`endif

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_overflow();
        test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Parametrised matrix keypad scanner; successor to the fixed 4x4 hex keypad FSM.
- Drives columns, synchronises raw row inputs internally and debounces press and release.
- Rejects multi-row presses and delivers one code per press over a valid/ready handshake.
- Optional auto-repeat while a key is held. Sits between the keypad pins and the consumer logic.

Parameters:
ROWS, 4, number of row inputs (>=2)
COLS, 4, number of column drive outputs (>=2)
SCAN_HOLD, 3, cycles each column is driven in SCAN before sampling (>=3: 2 sync + 1 settle)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or release (>=1)
REPEAT_DELAY, 64, cycles held before the first repeat (KEYPAD_REPEAT_EN only)
REPEAT_PERIOD, 16, cycles between later repeats (KEYPAD_REPEAT_EN only)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
row  in  ROWS  raw row sense, active-high, asynchronous to clock
col  out  COLS  column drive, active-high
code  out  CODE_W  key index = row_idx*COLS + col_idx; CODE_W = clog2(ROWS*COLS)
valid  out  1  code is available
ready  in  1  consumer accepts code when valid && ready
multi_key  out  1  one-cycle pulse: press with more than one row active rejected
overflow  out  1  one-cycle pulse: new code event dropped because valid && !ready

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, col=all ones, code=0, valid=0, multi_key=0, overflow=0, all counters 0.
- Reset asserted mid-operation clears everything immediately, including a pending code.
- row passes through a 2-flop synchroniser (s_row). The FSM uses only s_row.
- IDLE: col=all ones. s_row!=0 -> SCAN with col_idx=0, hold counter 0.
- SCAN: col one-hot at col_idx. On the SCAN_HOLD-th cycle, sample s_row:
  - nonzero -> DEBOUNCE, capture the pattern;
  - zero, col_idx<COLS-1 -> col_idx+1;
  - zero, col_idx==COLS-1 -> IDLE (glitch, no output).
- DEBOUNCE: column held. Counter increments while s_row equals the captured pattern.
  - Different nonzero pattern -> recapture, counter 0.
  - Zero -> back to SCAN at the next column, or IDLE if last.
  - Counter reaches DEBOUNCE_CYCLES -> HELD:
    - one-hot pattern: emit code;
    - multiple row bits: pulse multi_key, no emit.
- HELD: column held. s_row==0 -> RELEASE with counter 0.
- RELEASE: s_row nonzero -> HELD with no re-emit. DEBOUNCE_CYCLES consecutive zero cycles -> IDLE.
- Emit:
  - valid=0: load code and set valid on the next edge.
  - valid=1 && !ready: keep the old code, pulse overflow, drop the new code.
  - Emit in the same cycle as a handshake (valid && ready): load the new code, valid stays 1.
- valid && ready with no emit -> valid=0 next edge. code holds its value after valid falls.
- Latency from a raw press on column c, starting in IDLE, no bounce: valid rises exactly 4 + (c+1)*SCAN_HOLD + DEBOUNCE_CYCLES edges later. Defaults, c=0: 11 edges.
- Multi-column presses in the same row (ghosting) are not detected. The lowest scanned column wins.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In HELD with an accepted (one-hot) key, a repeat counter runs.
  - A new emit fires at REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - The counter clears on leaving HELD; RELEASE->HELD bounce does not restart it.
  - Repeats obey the same overflow rule.
- KEYPAD_REPEAT_EN undefined: no repeat logic, one emit per press. REPEAT_* parameters are ignored.

Decomposition:
- Package keypad_pkg: state enum (IDLE, SCAN, DEBOUNCE, HELD, RELEASE), code width function clog2, state encoding constants.
- Sub-module keypad_sync: parametrised-width 2-flop synchroniser with async active-low reset. Instantiated once with width ROWS.

Test Plan:
- Reset: reset_n=0 mid-HELD with valid=1 -> col=4'b1111, valid=0, code=0 immediately. Release reset, no keys -> stays IDLE.
- Single key row1/col2 held 100 cycles, ready=1 -> exactly one valid cycle with code=6, 4+3*3+4=17 edges after press. Repeat disabled.
- Bounce: row toggles 1-cycle pulses for 3 cycles, then stable -> no extra codes, single code emitted. A 2-cycle release glitch in HELD -> no re-emit.
- Rows 0 and 2 on column 1 pressed together -> multi_key pulses once, valid stays 0. After release, key 5 press -> code=5.
- ready=0; press key 3, release, press key 9 -> code=3 held valid, overflow pulses once at the key-9 emit. ready=1 -> valid drops, code stays 3.
- KEYPAD_REPEAT_EN, key 0 held 120 cycles, ready=1 -> emits at press, +64, +80, +96, +112 cycles. None after release.
